pipelined_shifter: RTL and testbench

- Parametrised, pipelined successor to the single-cycle combinational shifter in the EXU.
- Performs logical left, logical right and arithmetic right shifts, plus optional rotates, on an XLEN-bit operand.
- The log2(XLEN) shift steps are spread across NSTAGE register stages, with valid/ready handshakes on both sides.
- Sits between issue and writeback and carries an opaque tag so results can be matched to instructions.

---
 rtl/pipelined_shifter_if.sv | 31 +++
 rtl/pipelined_shifter.sv | 160 ++++++++++++++++
 tb/tb_pipelined_shifter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_shifter_if.sv
// Request/result channel bundle for pipelined_shifter.
// slave is the shifter's view; master is the issue/writeback side.
interface pipelined_shifter_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  localparam int SHAMT_W = $clog2(XLEN);

  logic               in_valid;
  logic               in_ready;
  logic [XLEN-1:0]    in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [2:0]         in_op;
  logic [TAG_W-1:0]   in_tag;

  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_data;
  logic [TAG_W-1:0]   out_tag;
  logic               out_err;

  modport slave (
    input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_err
  );

  modport master (
    output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_err
  );
endinterface

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter: SLL/SRL/SRA (+ROL/ROR when SHIFT_ROTATE_EN is
// defined). The log2(XLEN) shift steps are spread over NSTAGE register
// stages; the last stage register drives the result channel directly.
// Optional macro: SHIFT_ROTATE_EN enables rotates; otherwise ops 011/100
// are reported as illegal and pass the operand through.
module pipelined_shifter #(
  parameter int XLEN   = 32,
  parameter int NSTAGE = 2,
  parameter int TAG_W  = 5
) (
  input logic                clk,
  input logic                rst_n,
  input logic                flush,
  pipelined_shifter_if.slave bus
);
  localparam int SHAMT_W = $clog2(XLEN);
  localparam int SPS     = (SHAMT_W + NSTAGE - 1) / NSTAGE;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
`ifdef SHIFT_ROTATE_EN
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;
`endif

  // Applies the log2 steps lo..hi-1 selected by sh. Illegal requests pass
  // through untouched. SRA keeps bit XLEN-1 in place at every step, so the
  // fill is always the original sign bit.
  function automatic logic [XLEN-1:0] shift_steps(
    input logic [XLEN-1:0]    d,
    input logic [SHAMT_W-1:0] sh,
    input logic [2:0]         op,
    input logic               err,
    input int                 lo,
    input int                 hi
  );
    logic [XLEN-1:0] r;
    r = d;
    for (int j = 0; j < SHAMT_W; j++) begin
      if (!err && j >= lo && j < hi && sh[j]) begin
        case (op)
          OP_SLL:  r = r << (1 << j);
          OP_SRL:  r = r >> (1 << j);
          OP_SRA:  r = $unsigned($signed(r) >>> (1 << j));
`ifdef SHIFT_ROTATE_EN
          OP_ROL:  r = (r << (1 << j)) | (r >> (XLEN - (1 << j)));
          OP_ROR:  r = (r >> (1 << j)) | (r << (XLEN - (1 << j)));
`endif
          default: r = r;
        endcase
      end
    end
    return r;
  endfunction

  logic                r_vld   [NSTAGE];
  logic [XLEN-1:0]     r_data  [NSTAGE];
  logic [SHAMT_W-1:0]  r_shamt [NSTAGE];
  logic [2:0]          r_op    [NSTAGE];
  logic [TAG_W-1:0]    r_tag   [NSTAGE];
  logic                r_err   [NSTAGE];

  logic [NSTAGE-1:0]   w_adv;
  logic                w_in_ready;
  logic                w_err_in;

`ifdef SHIFT_ROTATE_EN
  assign w_err_in = (bus.in_op > 3'd4);
`else
  assign w_err_in = (bus.in_op > 3'd2);
`endif

  // Stage k may advance when it or any later stage holds a bubble, or the
  // consumer takes the result; written without a chain so it stays acyclic.
  always_comb begin
    w_adv = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      w_adv[k] = bus.out_ready;
      for (int m = 0; m < NSTAGE; m++) begin
        if (m >= k && !r_vld[m]) w_adv[k] = 1'b1;
      end
    end
  end

  assign w_in_ready = w_adv[0] & ~flush;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_vld[NSTAGE-1];
  assign bus.out_data  = r_data[NSTAGE-1];
  assign bus.out_tag   = r_tag[NSTAGE-1];
  assign bus.out_err   = r_err[NSTAGE-1];

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    localparam int LO = k * SPS;
    localparam int HI = ((k + 1) * SPS > SHAMT_W) ? SHAMT_W : (k + 1) * SPS;

    logic [XLEN-1:0]    w_d;
    logic [SHAMT_W-1:0] w_sh;
    logic [2:0]         w_op;
    logic [TAG_W-1:0]   w_tag;
    logic               w_err;
    logic               w_v;
    logic [XLEN-1:0]    w_res;

    if (k == 0) begin : g_src
      assign w_d   = bus.in_data;
      assign w_sh  = bus.in_shamt;
      assign w_op  = bus.in_op;
      assign w_tag = bus.in_tag;
      assign w_err = w_err_in;
      assign w_v   = bus.in_valid & w_in_ready;
    end else begin : g_src
      assign w_d   = r_data[k-1];
      assign w_sh  = r_shamt[k-1];
      assign w_op  = r_op[k-1];
      assign w_tag = r_tag[k-1];
      assign w_err = r_err[k-1];
      assign w_v   = r_vld[k-1];
    end

    assign w_res = shift_steps(w_d, w_sh, w_op, w_err, LO, HI);

    // Stage valid: killed by reset or flush, otherwise follows the upstream valid on advance.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        r_vld[k] <= 1'b0;
      else if (flush)    r_vld[k] <= 1'b0;
      else if (w_adv[k]) r_vld[k] <= w_v;
    end

    if (k == NSTAGE - 1) begin : g_out
      // Output stage payload: cleared by reset, loaded only with valid data so it holds under backpressure.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_data[k]  <= '0;
          r_shamt[k] <= '0;
          r_op[k]    <= '0;
          r_tag[k]   <= '0;
          r_err[k]   <= 1'b0;
        end else if (w_adv[k] && w_v) begin
          r_data[k]  <= w_res;
          r_shamt[k] <= w_sh;
          r_op[k]    <= w_op;
          r_tag[k]   <= w_tag;
          r_err[k]   <= w_err;
        end
      end
    end else begin : g_mid
      // Intermediate payload: no reset, loaded only when a valid entry moves in.
      always_ff @(posedge clk) begin
        if (w_adv[k] && w_v) begin
          r_data[k]  <= w_res;
          r_shamt[k] <= w_sh;
          r_op[k]    <= w_op;
          r_tag[k]   <= w_tag;
          r_err[k]   <= w_err;
        end
      end
    end
  end
endmodule

// File: tb/tb_pipelined_shifter.sv
// Self-checking bench for pipelined_shifter (XLEN=32, NSTAGE=2, TAG_W=5).
module tb_pipelined_shifter;
  localparam int XLEN = 32;
  localparam int NSTAGE = 2;
  localparam int TAG_W = 5;
`ifdef SHIFT_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  pipelined_shifter_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  pipelined_shifter #(.XLEN(XLEN), .NSTAGE(NSTAGE), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  function automatic logic ref_err(input logic [2:0] op);
    return (op > 3'd4) || (!ROT && (op == 3'd3 || op == 3'd4));
  endfunction

  function automatic logic [31:0] ref_data(input logic [31:0] d, input logic [4:0] s,
                                           input logic [2:0] op);
    if (ref_err(op)) return d;
    case (op)
      3'd0: return d << s;
      3'd1: return d >> s;
      3'd2: return $unsigned($signed(d) >>> s);
      3'd3: return (s == 0) ? d : ((d << s) | (d >> (32 - s)));
      default: return (s == 0) ? d : ((d >> s) | (d << (32 - s)));
    endcase
  endfunction

  function automatic logic [37:0] ref_pack(input logic [31:0] d, input logic [4:0] s,
                                           input logic [2:0] op, input logic [4:0] tag);
    return {ref_err(op), tag, ref_data(d, s, op)};
  endfunction

  task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] s,
                       input logic [2:0] op, input logic [4:0] tag);
    bus.in_valid = v; bus.in_data = d; bus.in_shamt = s; bus.in_op = op; bus.in_tag = tag;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; drive(1'b0, 0, 0, 0, 0); bus.out_ready = 1'b1; flush = 1'b0;
    #12;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); else passed++;
    checks++; if (bus.out_data !== 32'h0) $display("FAIL reset_out_data got=%h exp=0", bus.out_data); else passed++;
    checks++; if (bus.out_tag !== 5'h0) $display("FAIL reset_out_tag got=%h exp=0", bus.out_tag); else passed++;
    checks++; if (bus.out_err !== 1'b0) $display("FAIL reset_out_err got=%b exp=0", bus.out_err); else passed++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); else passed++;
  endtask

  // Back-to-back directed vectors; each result must appear exactly NSTAGE cycles after issue.
  task automatic test_directed();
    logic [31:0] vd [8] = '{32'h1, 32'h800000F0, 32'h800000F0, 32'h12345678,
                            32'h12345678, 32'hDEADBEEF, 32'h7FFFFFFF, 32'hCAFEF00D};
    logic [4:0]  vs [8] = '{5'd31, 5'd4, 5'd4, 5'd8, 5'd0, 5'd5, 5'd31, 5'd0};
    logic [2:0]  vo [8] = '{3'd0, 3'd2, 3'd1, 3'd4, 3'd3, 3'd7, 3'd2, 3'd0};
    logic [31:0] ve [8] = '{32'h80000000, 32'hF800000F, 32'h0800000F,
                            ROT ? 32'h78123456 : 32'h12345678, 32'h12345678,
                            32'hDEADBEEF, 32'h0, 32'hCAFEF00D};
    logic        vr [8] = '{1'b0, 1'b0, 1'b0, !ROT, !ROT, 1'b1, 1'b0, 1'b0};
    bus.out_ready = 1'b1;
    for (int t = 0; t < 8 + NSTAGE; t++) begin
      @(posedge clk); #1;
      if (t < 8) drive(1'b1, vd[t], vs[t], vo[t], 5'(t + 7)); else drive(1'b0, 0, 0, 0, 0);
      @(negedge clk);
      if (t < NSTAGE) begin
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL dir_latency t=%0d out_valid=%b exp=0", t, bus.out_valid); else passed++;
      end else begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== ve[t-NSTAGE] ||
            bus.out_tag !== 5'(t - NSTAGE + 7) || bus.out_err !== vr[t-NSTAGE])
          $display("FAIL dir_vec%0d got v=%b d=%h tag=%0d err=%b exp v=1 d=%h tag=%0d err=%b",
                   t - NSTAGE, bus.out_valid, bus.out_data, bus.out_tag, bus.out_err,
                   ve[t-NSTAGE], 5'(t - NSTAGE + 7), vr[t-NSTAGE]);
        else passed++;
      end
    end
  endtask

  // Random traffic with random backpressure against a queue scoreboard.
  task automatic test_random();
    logic [37:0] q[$];
    logic [37:0] exp_v;
    logic hold = 1'b0;
    logic [37:0] held = '0;
    int outs = 0, ins = 0;
    for (int cyc = 0; cyc < 420; cyc++) begin
      @(posedge clk); #1;
      if (cyc < 380) begin
        drive(($urandom_range(0, 9) < 7), $urandom, 5'($urandom), 3'($urandom), 5'($urandom));
        bus.out_ready = ($urandom_range(0, 9) < 6);
      end else begin
        drive(1'b0, 0, 0, 0, 0); bus.out_ready = 1'b1;
      end
      @(negedge clk);
      if (hold) begin
        checks++;
        if (bus.out_valid !== 1'b1 || {bus.out_err, bus.out_tag, bus.out_data} !== held)
          $display("FAIL rnd_hold got v=%b %h exp v=1 %h", bus.out_valid, {bus.out_err, bus.out_tag, bus.out_data}, held);
        else passed++;
      end
      hold = bus.out_valid && !bus.out_ready;
      held = {bus.out_err, bus.out_tag, bus.out_data};
      if (bus.out_valid && bus.out_ready) begin
        outs++;
        exp_v = (q.size() > 0) ? q.pop_front() : 38'h3F_FFFF_FFFF;
        checks++;
        if ({bus.out_err, bus.out_tag, bus.out_data} !== exp_v)
          $display("FAIL rnd_result%0d got %h exp %h", outs, {bus.out_err, bus.out_tag, bus.out_data}, exp_v);
        else passed++;
      end
      if (bus.in_valid && bus.in_ready) begin
        ins++;
        q.push_back(ref_pack(bus.in_data, bus.in_shamt, bus.in_op, bus.in_tag));
      end
    end
    checks++; if (outs != ins || q.size() != 0) $display("FAIL rnd_count got=%0d exp=%0d", outs, ins); else passed++;
  endtask

  // Stall the output while streaming 4 requests, then release and collect them in order.
  task automatic test_backpressure();
    logic [37:0] q[$];
    logic [37:0] exp_v;
    logic [31:0] d [4];
    logic [31:0] held = '0;
    int idx = 0, got = 0;
    for (int i = 0; i < 4; i++) d[i] = $urandom | 32'h1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(posedge clk); #1;
      bus.out_ready = (cyc >= 7);
      if (idx < 4) drive(1'b1, d[idx], 5'(idx * 3 + 1), 3'(idx % 3), 5'(20 + idx)); else drive(1'b0, 0, 0, 0, 0);
      @(negedge clk);
      if (cyc == 3) held = bus.out_data;
      if (cyc > 3 && cyc < 7) begin
        checks++; if (bus.out_data !== held) $display("FAIL bp_stable cyc=%0d got=%h exp=%h", cyc, bus.out_data, held); else passed++;
      end
      if (cyc == 6) begin
        checks++; if (bus.in_ready !== 1'b0 || idx != NSTAGE)
          $display("FAIL bp_full in_ready=%b accepted=%0d exp in_ready=0 accepted=%0d", bus.in_ready, idx, NSTAGE);
        else passed++;
      end
      if (bus.out_valid && bus.out_ready) begin
        got++;
        exp_v = (q.size() > 0) ? q.pop_front() : 38'h3F_FFFF_FFFF;
        checks++;
        if ({bus.out_err, bus.out_tag, bus.out_data} !== exp_v)
          $display("FAIL bp_result%0d got %h exp %h", got, {bus.out_err, bus.out_tag, bus.out_data}, exp_v);
        else passed++;
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(ref_pack(bus.in_data, bus.in_shamt, bus.in_op, bus.in_tag));
        idx++;
      end
    end
    checks++; if (got != 4 || q.size() != 0) $display("FAIL bp_count got=%0d exp=4", got); else passed++;
  endtask

  // Two requests in flight plus one presented during flush: none may come out.
  task automatic test_flush();
    bus.out_ready = 1'b0;
    for (int t = 0; t < 2; t++) begin
      @(posedge clk); #1; drive(1'b1, 32'h0F0F0F0F, 5'(t + 1), 3'd0, 5'(t + 1));
    end
    @(posedge clk); #1; drive(1'b1, 32'h33333333, 5'd3, 3'd1, 5'd3); flush = 1'b1;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0) $display("FAIL flush_in_ready got=%b exp=0", bus.in_ready); else passed++;
    @(posedge clk); #1; flush = 1'b0; drive(1'b0, 0, 0, 0, 0); bus.out_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) $display("FAIL flush_no_out t=%0d got=%b exp=0", t, bus.out_valid); else passed++;
      @(posedge clk); #1;
    end
    drive(1'b1, 32'h00000003, 5'd2, 3'd0, 5'd9);
    @(posedge clk); #1; drive(1'b0, 0, 0, 0, 0);
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0000000C || bus.out_tag !== 5'd9 || bus.out_err !== 1'b0)
      $display("FAIL flush_after got v=%b d=%h tag=%0d err=%b exp v=1 d=0000000c tag=9 err=0",
               bus.out_valid, bus.out_data, bus.out_tag, bus.out_err);
    else passed++;
  endtask

  // Asynchronous reset between edges with results pending.
  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1; drive(1'b1, 32'hA5A5A5A5, 5'd0, 3'd0, 5'(t + 1));
    end
    @(posedge clk); #1; drive(1'b0, 0, 0, 0, 0);
    #2;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hA5A5A5A5)
      $display("FAIL arst_pre got v=%b d=%h exp v=1 d=a5a5a5a5", bus.out_valid, bus.out_data); else passed++;
    rst_n = 1'b0; #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0)
      $display("FAIL arst_immediate got v=%b d=%h exp v=0 d=0", bus.out_valid, bus.out_data); else passed++;
    @(negedge clk); @(negedge clk); rst_n = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL arst_in_ready got=%b exp=1", bus.in_ready); else passed++;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) $display("FAIL arst_stale t=%0d got=%b exp=0", t, bus.out_valid); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_flush();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout passed=%0d total=%0d", passed, checks);
    $fatal(1, "timeout");
  end
endmodule
